risc_v_32_hazard_ctrl: RTL and testbench
========================================

Name: risc_v_32_hazard_ctrl

Overview:
- Parametrised next-generation hazard/stall controller for the RV32IM pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards, ignoring x0 and unused source operands.
- Stalls the front end and bubbles EX/MEM for multi-cycle MUL/DIV using an internal latency FSM.
- Applies branch/trap flushes and keeps a saturating stall-cycle performance counter.

Parameters:
CTRL_W, 37, width of decoded control vector passed ID to ID/EX
REG_AW, 5, register address width
MUL_LAT, 1, MUL result latency in cycles (>=1); 1 means no stall
DIV_LAT, 33, DIV/REM latency in cycles (>=1, <=2^LAT_W)
LAT_W, 6, width of internal latency counter
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
memread_ex  in  1  EX instruction is a load
rd_ex  in  REG_AW  EX destination register
rs1_id  in  REG_AW  ID source 1
rs2_id  in  REG_AW  ID source 2
rs1_used  in  1  ID instruction reads rs1
rs2_used  in  1  ID instruction reads rs2
inst_decode  in  CTRL_W  ID decoded control vector
mdu_issue  in  1  EX holds a valid M-extension instruction
mdu_is_div  in  1  that instruction is DIV/DIVU/REM/REMU
flush_req  in  1  redirect (taken branch/jump/trap) resolved in EX
perf_clr  in  1  synchronous clear of stall_cycles
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID update enable
idex_write  out  1  ID/EX update enable
ifid_flush  out  1  zero IF/ID on next edge
ex_bubble  out  1  inject bubble into EX/MEM
ctrl_out  out  CTRL_W  control vector into ID/EX (zero = bubble)
mdu_busy  out  1  MDU FSM in BUSY
mdu_done  out  1  MDU result valid this cycle (release cycle)
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- While rst_n=0 (async): state IDLE, lat_cnt=0, stall_cycles=0. All enables, flush, bubble, mdu_busy and mdu_done are 0. ctrl_out=0.
- After reset with idle inputs: pc_write=ifid_write=idex_write=1, all other outputs 0, ctrl_out=inst_decode.
- Load-use hazard, combinational, same cycle: lu = memread_ex & rd_ex!=0 & ((rs1_used & rd_ex==rs1_id) | (rs2_used & rd_ex==rs2_id)).
  - Response: pc_write=ifid_write=0, idex_write=1, ctrl_out=0.
  - Exactly one bubble per hazard; on the next cycle the load is in MEM and lu clears naturally.
- MDU FSM, states IDLE and BUSY. Let L = mdu_is_div ? DIV_LAT : MUL_LAT.
  - IDLE & mdu_issue & L>=2: ms=1; next state BUSY, lat_cnt<=L-2.
  - IDLE & mdu_issue & L==1: ms=0 and mdu_done=1 that cycle.
  - BUSY & lat_cnt!=0: ms=1, lat_cnt decrements.
  - BUSY & lat_cnt==0: ms=0, mdu_done=1, next state IDLE. This is the release cycle; the instruction leaves EX on this edge.
  - Net effect: exactly L-1 stall cycles, and mdu_done fires L-1 cycles after first issue.
  - mdu_issue remains high during BUSY. The FSM must not re-trigger in BUSY or in the release cycle.
  - mdu_is_div is sampled only at IDLE entry.
  - ms=1 response: pc_write=ifid_write=idex_write=0, ex_bubble=1, ctrl_out=inst_decode (ID/EX is held).
- lu and ms together: ms dominates (idex_write=0). lu re-evaluates after release.
- flush_req has highest priority, in any state:
  - Response: ifid_flush=1, ctrl_out=0, pc_write=1, ifid_write=1, idex_write=1, ex_bubble=0.
  - In BUSY: abort to IDLE next edge, lat_cnt<=0, no mdu_done.
  - In IDLE with mdu_issue: no BUSY entry.
- stall_cycles: increments every cycle with rst_n=1 and pc_write=0, saturating at all-ones.
  - perf_clr wins over increment (counter becomes 0).
- Elaboration check: DIV_LAT-2 and MUL_LAT-2 must fit LAT_W; assertion fires otherwise.

Decomposition:
- Package risc_v_32_hazard_pkg holds:
  - state enum {IDLE, BUSY};
  - default latency constants;
  - CTRL_W default;
  - a function computing the load-use compare.
- Sub-module risc_v_32_mdu_stall_timer contains the FSM and lat_cnt. Inputs: issue, is_div, abort. Outputs: ms, busy, done.
- Top level contains the lu logic, priority muxing and the perf counter.

Test Plan:
- Load-use: memread_ex=1, rd_ex=5, rs1_id=5, rs1_used=1 -> one cycle with pc_write=0, ctrl_out=0. stall_cycles goes 0->1.
- x0/unused exemption: rd_ex=0, rs1_id=0 -> no stall. Separately, rd_ex=7, rs2_id=7, rs2_used=0 -> no stall.
- DIV with DIV_LAT=33: mdu_issue=1, is_div=1 held -> pc_write=0 and ex_bubble=1 for exactly 32 cycles. mdu_done pulses on cycle 33 only, with no re-trigger. MUL with MUL_LAT=1 -> zero stalls, mdu_done=1 in the issue cycle.
- Flush abort: flush_req pulsed on the 10th BUSY cycle -> that cycle ifid_flush=1, ctrl_out=0, pc_write=1. State returns to IDLE and mdu_done never fires.
- Async reset mid-BUSY: rst_n low between clock edges -> outputs go to reset values immediately. After release, a fresh DIV stalls the full 32 cycles.
- Counter: force CNT_W=4 and 20 stall cycles -> stall_cycles saturates at 15. perf_clr together with a stall cycle -> counter reads 0.

Source files
------------

// File: rtl/risc_v_32_hazard_pkg.sv
// Purpose : shared types, default parameters and the load-use compare for the RV32IM hazard controller.
// Latency : n/a (package).
// Backpressure: n/a (package).
package risc_v_32_hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int DEF_CTRL_W  = 37;
    localparam int DEF_REG_AW  = 5;
    localparam int DEF_MUL_LAT = 1;
    localparam int DEF_DIV_LAT = 33;
    localparam int DEF_LAT_W   = 6;
    localparam int DEF_CNT_W   = 32;

    // Register addresses are passed zero-extended to 32 bits so one function
    // serves any REG_AW up to 32. Address 0 (x0) never creates a dependency.
    function automatic logic load_use_hit(
        input logic        memread,
        input logic [31:0] rd,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic        rs1_used,
        input logic        rs2_used
    );
        return memread && (rd != 32'd0) &&
               ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
    endfunction

endpackage

// File: rtl/risc_v_32_mdu_stall_timer.sv
// Purpose : latency FSM for multi-cycle MUL/DIV; asserts ms_o for L-1 cycles, done_o on the release cycle.
// Latency : ms_o/done_o combinational from issue_i and state; state/lat_cnt registered.
// Backpressure: abort_i (flush) returns to IDLE next edge with no done_o; issue_i ignored while BUSY.
//
// Ports: clk, rst_n            clock, async active-low reset
//        issue_i, is_div_i     M-extension op valid in EX, op is DIV/REM (sampled at IDLE only)
//        abort_i               pipeline redirect, kills the in-flight op
//        ms_o, busy_o, done_o  stall request, FSM in BUSY, result valid this cycle
module risc_v_32_mdu_stall_timer
    import risc_v_32_hazard_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int LAT_W   = DEF_LAT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_i,
    input  logic is_div_i,
    input  logic abort_i,
    output logic ms_o,
    output logic busy_o,
    output logic done_o
);

    localparam bit MUL_MULTI = (MUL_LAT >= 2);
    localparam bit DIV_MULTI = (DIV_LAT >= 2);
    // Counter is loaded with L-2: the issue cycle is the first stall, BUSY
    // counts down the rest, and lat_cnt==0 in BUSY is the release cycle.
    localparam logic [LAT_W-1:0] MUL_RELOAD = MUL_MULTI ? LAT_W'(MUL_LAT - 2) : '0;
    localparam logic [LAT_W-1:0] DIV_RELOAD = DIV_MULTI ? LAT_W'(DIV_LAT - 2) : '0;

    if ((MUL_LAT < 1) || (DIV_LAT < 1) ||
        (MUL_LAT - 2 > (1 << LAT_W) - 1) || (DIV_LAT - 2 > (1 << LAT_W) - 1)) begin : g_lat_chk
        $error("risc_v_32_mdu_stall_timer: MUL_LAT/DIV_LAT out of range for LAT_W");
    end

    mdu_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             sel_multi;
    logic [LAT_W-1:0] sel_reload;

    always_comb begin
        ms_o       = 1'b0;
        done_o     = 1'b0;
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        sel_multi  = is_div_i ? DIV_MULTI  : MUL_MULTI;
        sel_reload = is_div_i ? DIV_RELOAD : MUL_RELOAD;
        case (state_q)
            IDLE: begin
                if (issue_i && !abort_i) begin
                    if (sel_multi) begin
                        ms_o      = 1'b1;
                        state_d   = BUSY;
                        lat_cnt_d = sel_reload;
                    end else begin
                        done_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                end else if (lat_cnt_q != '0) begin
                    ms_o      = 1'b1;
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else begin
                    // Release: the op leaves EX on this edge, so return to IDLE
                    // without looking at issue_i again.
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign busy_o = (state_q == BUSY);

endmodule

// File: rtl/risc_v_32_hazard_ctrl.sv
// Purpose : RV32IM hazard/stall controller: load-use stall, MDU stall, flush, stall-cycle counter.
// Latency : all control outputs combinational in the same cycle; stall_cycles updates on the edge.
// Backpressure: flush > MDU stall (freeze IF/ID/EX, bubble EX/MEM) > load-use (freeze IF/ID, bubble ID/EX).
//
// Ports: memread_ex, rd_ex            load in EX and its destination
//        rs1_id/rs2_id, rs*_used      ID sources and whether they are read
//        inst_decode -> ctrl_out      ID control vector, zeroed for a bubble/flush
//        mdu_issue, mdu_is_div        M-extension op in EX
//        flush_req, perf_clr          redirect from EX, clear of stall_cycles
//        pc_write, ifid_write, idex_write, ifid_flush, ex_bubble, mdu_busy, mdu_done, stall_cycles
module risc_v_32_hazard_ctrl
    import risc_v_32_hazard_pkg::*;
#(
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int LAT_W   = DEF_LAT_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [CTRL_W-1:0] inst_decode,
    input  logic              mdu_issue,
    input  logic              mdu_is_div,
    input  logic              flush_req,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              ifid_flush,
    output logic              ex_bubble,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lu;
    logic             ms;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign lu = load_use_hit(memread_ex, 32'(rd_ex), 32'(rs1_id), 32'(rs2_id),
                             rs1_used, rs2_used);

    risc_v_32_mdu_stall_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .LAT_W   (LAT_W)
    ) u_mdu_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_i  (mdu_issue),
        .is_div_i (mdu_is_div),
        .abort_i  (flush_req),
        .ms_o     (ms),
        .busy_o   (busy),
        .done_o   (done)
    );

    // Outputs are forced low directly by rst_n so the pipeline sees the
    // reset values as soon as reset asserts, not at the next edge.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        ifid_flush = 1'b0;
        ex_bubble  = 1'b0;
        ctrl_out   = inst_decode;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ctrl_out   = '0;
        end else if (flush_req) begin
            ifid_flush = 1'b1;
            ctrl_out   = '0;
        end else if (ms) begin
            // ID/EX is held, so ctrl_out passes through unchanged.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ex_bubble  = 1'b1;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_out   = '0;
        end
    end

    assign mdu_busy = busy;
    assign mdu_done = done & rst_n;

    always_comb begin
        stall_d = stall_q;
        if (perf_clr) begin
            stall_d = '0;
        end else if (!pc_write && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_risc_v_32_hazard_ctrl.sv
// Purpose : self-checking bench for risc_v_32_hazard_ctrl (vector table + multi-cycle sequences).
// Latency : expected outputs sampled on the falling edge of the cycle they are driven in.
// Backpressure: n/a (bench).
module tb_risc_v_32_hazard_ctrl;

    localparam int CW = 37;
    localparam logic [CW-1:0] D1 = 37'h1_2345_6789;
    localparam logic [CW-1:0] D2 = 37'h0A_5A5A_5A5A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memread_ex;
    logic [4:0]    rd_ex, rs1_id, rs2_id;
    logic          rs1_used, rs2_used;
    logic [CW-1:0] inst_decode;
    logic          mdu_issue, mdu_is_div, flush_req, perf_clr;

    logic          pc_write, ifid_write, idex_write, ifid_flush, ex_bubble;
    logic [CW-1:0] ctrl_out;
    logic          mdu_busy, mdu_done;
    logic [31:0]   stall_cycles;

    logic          pc_write_c, ifid_write_c, idex_write_c, ifid_flush_c, ex_bubble_c;
    logic [CW-1:0] ctrl_out_c;
    logic          mdu_busy_c, mdu_done_c;
    logic [3:0]    stall_cycles_c;

    always #5 clk = ~clk;

    risc_v_32_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .memread_ex(memread_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .inst_decode(inst_decode), .mdu_issue(mdu_issue), .mdu_is_div(mdu_is_div),
        .flush_req(flush_req), .perf_clr(perf_clr), .pc_write(pc_write),
        .ifid_write(ifid_write), .idex_write(idex_write), .ifid_flush(ifid_flush),
        .ex_bubble(ex_bubble), .ctrl_out(ctrl_out), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance for saturation; shares all inputs with dut.
    risc_v_32_hazard_ctrl #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .memread_ex(memread_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .inst_decode(inst_decode), .mdu_issue(mdu_issue), .mdu_is_div(mdu_is_div),
        .flush_req(flush_req), .perf_clr(perf_clr), .pc_write(pc_write_c),
        .ifid_write(ifid_write_c), .idex_write(idex_write_c), .ifid_flush(ifid_flush_c),
        .ex_bubble(ex_bubble_c), .ctrl_out(ctrl_out_c), .mdu_busy(mdu_busy_c),
        .mdu_done(mdu_done_c), .stall_cycles(stall_cycles_c)
    );

    typedef struct packed {
        logic          memread;
        logic [4:0]    rd, rs1, rs2;
        logic          rs1u, rs2u, issue, is_div, flush, clr;
    } in_t;

    typedef struct packed {
        logic          pc, ifid, idex, flush, bubble, busy, done;
        logic [CW-1:0] ctrl;
    } out_t;

    typedef struct {
        string         name;
        in_t           in;
        logic [CW-1:0] dec;
        out_t          exp;
    } vec_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    out_t   exp_q[$];
    string  nm_q[$];
    vec_t   tbl[12];

    function automatic out_t o(input bit pc, ifid, idex, fl, bub, busy, done,
                               input logic [CW-1:0] c);
        out_t r;
        r = {pc, ifid, idex, fl, bub, busy, done, c};
        return r;
    endfunction

    function automatic in_t mki(input bit mr, input logic [4:0] rd, rs1, rs2,
                                input bit r1u, r2u, iss, dv, fl, clr);
        in_t r;
        r = {mr, rd, rs1, rs2, r1u, r2u, iss, dv, fl, clr};
        return r;
    endfunction

    function automatic vec_t mkv(input string nm, input in_t i, input logic [CW-1:0] d,
                                 input out_t e);
        vec_t v;
        v.name = nm; v.in = i; v.dec = d; v.exp = e;
        return v;
    endfunction

    task automatic drive(input in_t v, input logic [CW-1:0] dec);
        memread_ex = v.memread; rd_ex = v.rd; rs1_id = v.rs1; rs2_id = v.rs2;
        rs1_used = v.rs1u; rs2_used = v.rs2u; mdu_issue = v.issue;
        mdu_is_div = v.is_div; flush_req = v.flush; perf_clr = v.clr;
        inst_decode = dec;
    endtask

    task automatic compare_out(input string nm, input out_t e);
        out_t a;
        a = {pc_write, ifid_write, idex_write, ifid_flush, ex_bubble, mdu_busy, mdu_done, ctrl_out};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (pc,ifid,idex,flush,bubble,busy,done,ctrl)", nm, a, e);
    endtask

    // Expected value is queued when stimulus goes out and retired at the falling edge.
    task automatic expect_cycle(input string nm, input out_t e);
        out_t  x;
        string n;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        x = exp_q.pop_front();
        n = nm_q.pop_front();
        compare_out(n, x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, e);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Full DIV: 32 stall cycles then the release cycle with mdu_done. is_div is
    // dropped mid-BUSY to show it only matters at IDLE entry.
    task automatic run_div(input string tag);
        in_t v;
        v = mki(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int c = 1; c <= 33; c++) begin
            if (c == 6) v.is_div = 1'b0;
            drive(v, D2);
            if (c < 33) expect_cycle(tag, o(0, 0, 0, 0, 1, c > 1, 0, D2));
            else        expect_cycle({tag, "_release"}, o(1, 1, 1, 0, 0, 1, 1, D2));
            next_edge();
        end
        drive('0, D1);
        expect_cycle({tag, "_after"}, o(1, 1, 1, 0, 0, 0, 0, D1));
        next_edge();
    endtask

    task automatic clear_cnt();
        drive(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), D1);
        next_edge();
        drive('0, D1);
    endtask

    initial begin
        in_t lu_v, v;

        tbl[0]  = mkv("idle",        mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), D1, o(1, 1, 1, 0, 0, 0, 0, D1));
        tbl[1]  = mkv("lu_rs1",      mki(1, 5, 5, 0, 1, 0, 0, 0, 0, 0), D1, o(0, 0, 1, 0, 0, 0, 0, '0));
        tbl[2]  = mkv("lu_rs2",      mki(1, 9, 3, 9, 1, 1, 0, 0, 0, 0), D2, o(0, 0, 1, 0, 0, 0, 0, '0));
        tbl[3]  = mkv("x0_exempt",   mki(1, 0, 0, 0, 1, 1, 0, 0, 0, 0), D1, o(1, 1, 1, 0, 0, 0, 0, D1));
        tbl[4]  = mkv("rs2_unused",  mki(1, 7, 1, 7, 1, 0, 0, 0, 0, 0), D2, o(1, 1, 1, 0, 0, 0, 0, D2));
        tbl[5]  = mkv("no_load",     mki(0, 5, 5, 0, 1, 0, 0, 0, 0, 0), D1, o(1, 1, 1, 0, 0, 0, 0, D1));
        tbl[6]  = mkv("mul_lat1",    mki(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), D1, o(1, 1, 1, 0, 0, 0, 1, D1));
        tbl[7]  = mkv("flush_div",   mki(0, 0, 0, 0, 0, 0, 1, 1, 1, 0), D1, o(1, 1, 1, 1, 0, 0, 0, '0));
        tbl[8]  = mkv("after_flush", mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), D2, o(1, 1, 1, 0, 0, 0, 0, D2));
        tbl[9]  = mkv("flush_lu",    mki(1, 5, 5, 0, 1, 0, 0, 0, 1, 0), D1, o(1, 1, 1, 1, 0, 0, 0, '0));
        tbl[10] = mkv("mul_plus_lu", mki(1, 4, 4, 0, 1, 0, 1, 0, 0, 0), D2, o(0, 0, 1, 0, 0, 0, 1, '0));
        tbl[11] = mkv("rs1_differ",  mki(1, 5, 6, 5, 1, 0, 0, 0, 0, 0), D1, o(1, 1, 1, 0, 0, 0, 0, D1));

        lu_v = mki(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);

        // Reset state while rst_n is low.
        rst_n = 1'b0;
        drive('0, D1);
        #3;
        compare_out("reset_outputs", o(0, 0, 0, 0, 0, 0, 0, '0));
        chk("reset_stall_cycles", stall_cycles, 0);
        #9 rst_n = 1'b1;
        next_edge();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in, tbl[i].dec);
            expect_cycle(tbl[i].name, tbl[i].exp);
            next_edge();
        end
        chk("cnt_after_table", stall_cycles, 3);

        // Single load-use: one bubble, counter 0 -> 1.
        clear_cnt();
        chk("cnt_cleared", stall_cycles, 0);
        drive(lu_v, D1);
        expect_cycle("lu_single", o(0, 0, 1, 0, 0, 0, 0, '0));
        next_edge();
        drive('0, D1);
        chk("cnt_lu_one", stall_cycles, 1);
        expect_cycle("lu_cleared", o(1, 1, 1, 0, 0, 0, 0, D1));
        next_edge();

        // perf_clr wins over a stall cycle.
        v = lu_v;
        v.clr = 1'b1;
        drive(v, D1);
        expect_cycle("lu_with_clr", o(0, 0, 1, 0, 0, 0, 0, '0));
        next_edge();
        chk("cnt_clr_wins", stall_cycles, 0);

        // 20 stall cycles: 32-bit counter reads 20, 4-bit counter saturates at 15.
        for (int c = 0; c < 20; c++) begin
            drive(lu_v, D2);
            expect_cycle("lu_run", o(0, 0, 1, 0, 0, 0, 0, '0));
            next_edge();
        end
        drive('0, D1);
        chk("cnt_20", stall_cycles, 20);
        chk("cnt_sat_15", {28'd0, stall_cycles_c}, 15);

        clear_cnt();
        run_div("div");
        chk("cnt_div_32", stall_cycles, 32);

        // Flush on the 10th BUSY cycle (cycle 11 counting the issue cycle).
        v = mki(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            drive(v, D2);
            expect_cycle("abort_stall", o(0, 0, 0, 0, 1, c > 1, 0, D2));
            next_edge();
        end
        v.flush = 1'b1;
        drive(v, D2);
        expect_cycle("abort_flush", o(1, 1, 1, 1, 0, 1, 0, '0));
        next_edge();
        for (int c = 0; c < 6; c++) begin
            drive('0, D1);
            expect_cycle("abort_idle", o(1, 1, 1, 0, 0, 0, 0, D1));
            next_edge();
        end

        // Async reset between edges in the middle of BUSY.
        v = mki(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            drive(v, D2);
            expect_cycle("pre_rst_stall", o(0, 0, 0, 0, 1, c > 1, 0, D2));
            next_edge();
        end
        drive(v, D2);
        #2 rst_n = 1'b0;
        #1;
        compare_out("async_rst_outputs", o(0, 0, 0, 0, 0, 0, 0, '0));
        chk("async_rst_cnt", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive('0, D1);
        next_edge();
        drive('0, D1);
        expect_cycle("post_rst_idle", o(1, 1, 1, 0, 0, 0, 0, D1));
        next_edge();
        run_div("div_after_rst");
        chk("cnt_div_after_rst", stall_cycles, 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
